// File: rtl/snn_evt_pkg.sv
// Shared types and event-word packing helpers for the spike event path.
// Pack functions work on 64-bit containers; callers truncate to their event width.
package snn_evt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EOT
    } state_t;

    localparam int EV_CNT_W  = 16;
    localparam int MAX_EVT_W = 64;

    function automatic int eot_bit(input int evt_w);
        return evt_w - 1;
    endfunction

    function automatic logic [MAX_EVT_W-1:0] field_mask(input int w);
        if (w >= MAX_EVT_W)
            return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [MAX_EVT_W-1:0] pack_spike(
        input logic [MAX_EVT_W-1:0] id,
        input logic [MAX_EVT_W-1:0] ts,
        input int                   idf,
        input int                   ts_w
    );
        return (id & field_mask(idf)) | ((ts & field_mask(ts_w)) << idf);
    endfunction

    // Marker reuses the spike layout; the id field carries the frame's event count.
    function automatic logic [MAX_EVT_W-1:0] pack_eot(
        input logic [MAX_EVT_W-1:0] count,
        input logic [MAX_EVT_W-1:0] ts,
        input int                   idf,
        input int                   ts_w,
        input int                   evt_w
    );
        return pack_spike(count, ts, idf, ts_w) | (64'd1 << eot_bit(evt_w));
    endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Combinational lowest-set-bit encoder: idx is the smallest i with vec[i]=1.
// idx is 0 when no bit is set; any tells the two cases apart.
module spike_prio_enc #(
    parameter int N = 64
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDXW = $clog2(N);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i])
                idx = IDXW'(i);
        end
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Serializes a per-timestep spike vector into event words, lowest neuron first,
// optionally closing each frame with an end-of-timestep marker carrying its event count.
module spike_event_encoder
    import snn_evt_pkg::*;
#(
    parameter int N        = 64,
    parameter int TS_W     = 8,
    parameter int EVT_W    = 32,
    parameter bit EMIT_EOT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                spk_v,
    output logic                spk_r,
    input  logic [N-1:0]        spk_vec,
    input  logic [TS_W-1:0]     spk_ts,
    output logic                out_v,
    input  logic                out_r,
    output logic [EVT_W-1:0]    out_d,
    output logic                busy,
    output logic [EV_CNT_W-1:0] ev_cnt
);

    localparam int IDXW = $clog2(N);
    localparam int IDF  = IDXW + 1;

    if (IDF + TS_W + 1 > EVT_W) begin : g_bad_width
        $error("spike_event_encoder: id, timestep and EOT flag do not fit in EVT_W");
    end
    if (EVT_W > MAX_EVT_W) begin : g_bad_evt_w
        $error("spike_event_encoder: EVT_W exceeds the packing container width");
    end

    state_t         state;
    logic [N-1:0]   pend;
    logic [TS_W-1:0] ts_q;
    logic [IDF-1:0] fcnt;
    logic [IDXW-1:0] low_idx;
    logic           pend_any;
    logic [N-1:0]   pend_clr;

    spike_prio_enc #(.N(N)) u_prio (
        .vec (pend),
        .idx (low_idx),
        .any (pend_any)
    );

    assign pend_clr = pend & ~(N'(1) << low_idx);

    assign spk_r = (state == IDLE);
    assign out_v = (state == SCAN) || (state == EOT);
    assign busy  = out_v;

    always_comb begin
        out_d = '0;
        case (state)
            SCAN:    out_d = EVT_W'(pack_spike(64'(low_idx), 64'(ts_q), IDF, TS_W));
            EOT:     out_d = EVT_W'(pack_eot(64'(fcnt), 64'(ts_q), IDF, TS_W, EVT_W));
            default: out_d = '0;
        endcase
    end

    // Frame FSM: reset wins over clk_en, and every handshake needs clk_en=1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            ts_q   <= '0;
            fcnt   <= '0;
            ev_cnt <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (spk_v) begin
                        pend <= spk_vec;
                        ts_q <= spk_ts;
                        fcnt <= '0;
                        if (|spk_vec)
                            state <= SCAN;
                        else if (EMIT_EOT)
                            state <= EOT;
                    end
                end
                SCAN: begin
                    if (out_r && pend_any) begin
                        pend <= pend_clr;
                        fcnt <= fcnt + 1'b1;
                        if (ev_cnt != '1)
                            ev_cnt <= ev_cnt + 1'b1;
                        if (pend_clr == '0)
                            state <= EMIT_EOT ? EOT : IDLE;
                    end
                end
                EOT: begin
                    if (out_r)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Producer-side front end for the synapse event queue.
- Accepts one per-timestep spike vector from a neuron layer and serializes its set bits, lowest index first, into event words on a valid/ready stream that feeds the synapse event FIFO write port.
- Optionally closes each timestep with an end-of-timestep (EOT) marker event carrying the frame's event count.
- Throughput: one event per enabled cycle.

Parameters:
- N, 64, number of neurons (spike vector width), N>=2.
- TS_W, 8, timestep field width.
- EVT_W, 32, event word width. Must equal the FIFO W.
- EMIT_EOT, 1, 1 = emit an EOT marker after each vector's events; 0 = no marker.
- Derived IDF = $clog2(N)+1, id/count field width. Elaboration-time check: IDF+TS_W+1 <= EVT_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- clk_en  in  1  global enable. When 0, all state is frozen.
- spk_v  in  1  spike vector valid.
- spk_r  out  1  encoder ready to accept a vector.
- spk_vec  in  N  spike bits, bit i = neuron i fired.
- spk_ts  in  TS_W  timestep of the vector.
- out_v  out  1  event valid (to FIFO in_v).
- out_r  in  1  downstream ready (from FIFO in_r).
- out_d  out  EVT_W  event word.
- busy  out  1  encoder is in state SCAN or EOT.
- ev_cnt  out  16  spike events emitted since reset, saturating at 16'hFFFF. EOT markers are not counted.

Behaviour:
- Reset: on a clk edge with rst_n=0 (synchronous; clk_en ignored):
  - state=IDLE, pend=0, ts_q=0, fcnt=0, ev_cnt=0.
  - Outputs: spk_r=1, out_v=0, out_d=0, busy=0.
- Event word layout:
  - spike event: [IDF-1:0] = neuron id, [IDF+TS_W-1:IDF] = ts_q, bit EVT_W-1 = 0, all other bits 0.
  - EOT marker: same layout, with bit EVT_W-1 = 1 and the id field holding fcnt (0..N).
- out_d is combinational from registered state and is 0 whenever out_v=0.
- Handshakes count only on an edge with clk_en=1:
  - accept = spk_v & spk_r
  - fire = out_v & out_r
- spk_r = (state==IDLE). out_v = (state==SCAN) | (state==EOT). Both are independent of clk_en.
- FSM:
  - IDLE on accept: pend<=spk_vec, ts_q<=spk_ts, fcnt<=0.
    - Next state SCAN if spk_vec!=0.
    - Otherwise EOT if EMIT_EOT=1, else stay in IDLE (empty vector, no output).
  - SCAN: out_d id = lowest set index of pend.
    - On fire: clear that bit in pend, fcnt+=1, ev_cnt+=1 (saturating).
    - If the pend after clearing is 0: go to EOT if EMIT_EOT=1, else IDLE. Otherwise stay in SCAN.
  - EOT: out_d is the marker. On fire: go to IDLE.
- Latency: the first event is valid in the cycle after accept. Back-to-back events issue on consecutive cycles while out_r=1.
- Stability: while out_v=1 and no fire, out_d is held constant (pend is unchanged).
- No overlap: a new vector is not accepted until the previous frame, including its EOT, has drained. spk_vec and spk_ts are sampled only on accept.
- The simultaneous spk_v and out_r case cannot conflict, since accept happens only in IDLE and fire only in SCAN/EOT.
- clk_en=0 mid-frame: the frame freezes, out_v and out_d hold, and no events are lost or duplicated.
- Reset mid-frame: the pending frame is discarded, no EOT is emitted, and the next cycle shows spk_r=1, out_v=0.

Decomposition:
- Package snn_evt_pkg holds:
  - the state enum {IDLE, SCAN, EOT}
  - the EOT flag bit position function
  - event pack functions for the spike and marker words, taking (id/count, ts) with widths as arguments
  - the constant EV_CNT_W=16
- Sub-module spike_prio_enc #(N): combinational lowest-set-bit encoder.
  - Inputs: vec[N].
  - Outputs: idx[$clog2(N)] and any.
  - It is the only sub-module.

Test Plan:
- N=64, EMIT_EOT=1, out_r=1, spk_vec bits {3,17,63} set, spk_ts=5:
  - Events are id 3, 17, 63 with ts=5, on 3 consecutive cycles starting 1 cycle after accept.
  - Then a marker 32'h8000_0283 (ts=5, count=3).
  - spk_r returns to 1 one cycle after the marker fires; ev_cnt=3.
- Empty vector, EMIT_EOT=1: a single marker with count=0. With EMIT_EOT=0: no out_v, and spk_r stays 1.
- Backpressure: out_r=0 for 4 cycles during the second event:
  - out_d stays at id 17 with out_v=1.
  - The sequence resumes with no drop or duplicate.
- clk_en toggling 1/0 every cycle with all 64 bits set: ids 0..63 emitted in order, then marker count=64 (id field 7'd64).
- rst_n=0 asserted after 2 of 3 events:
  - Next cycle: out_v=0, spk_r=1, ev_cnt=0.
  - A new vector {0} then yields id 0 and marker count=1.
- Saturation: drive 1100 full vectors (70400 events): ev_cnt holds 16'hFFFF.
